// File: rtl/vga_sync_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_sync_timing_gen
//   Free-running VGA raster timing generator clocked by the pixel clock.
//   Two registered counters (h_cnt, v_cnt) walk the raster. Every output is a
//   combinational decode of those counters, so all outputs line up in the
//   same cycle as the coordinates they describe. Each line and each frame
//   starts with active video, followed by front porch, sync and back porch.
//
// Ports
//   in_vga_clk   in   1   pixel clock, all state changes on the rising edge
//   in_reset     in   1   synchronous active-high reset, restarts at (0,0)
//   out_pixel_x  out  10  horizontal counter (exceeds active range in blank)
//   out_pixel_y  out  10  vertical counter (exceeds active range in blank)
//   out_blank_n  out  1   1 = active video, 0 = blanking (forced 0 in reset)
//   out_h_sync   out  1   horizontal sync, asserted level = H_SYNC_POL
//   out_v_sync   out  1   vertical sync, asserted level = V_SYNC_POL
// ----------------------------------------------------------------------------
module vga_sync_timing_gen #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter bit          H_SYNC_POL = 1'b0,
    parameter bit          V_SYNC_POL = 1'b0
) (
    input  logic       in_vga_clk,
    input  logic       in_reset,
    output logic [9:0] out_pixel_x,
    output logic [9:0] out_pixel_y,
    output logic       out_blank_n,
    output logic       out_h_sync,
    output logic       out_v_sync
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Decode boundaries are 11 bits wide: a window end may equal 1024 when
    // the back porch is zero and the total sits at the 1024 ceiling.
    localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
    localparam logic [10:0] H_SYN_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYN_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_SYN_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYN_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic [10:0] h_ext;
    logic [10:0] v_ext;
    logic        h_wrap;
    logic        h_sync_on;
    logic        v_sync_on;

    assign h_wrap = (h_cnt == H_LAST);

    always_ff @(posedge in_vga_clk) begin
        if (in_reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            // Vertical advances only on the line wrap, so v_sync edges
            // coincide with h_cnt returning to 0.
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    assign h_ext     = {1'b0, h_cnt};
    assign v_ext     = {1'b0, v_cnt};
    assign h_sync_on = (h_ext >= H_SYN_BEG) && (h_ext < H_SYN_END);
    assign v_sync_on = (v_ext >= V_SYN_BEG) && (v_ext < V_SYN_END);

    assign out_pixel_x = h_cnt;
    assign out_pixel_y = v_cnt;

    // Reset forces blanking and deasserted syncs even before the counters
    // have been cleared by the first reset edge.
    assign out_blank_n = !in_reset && (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
    assign out_h_sync  = (h_sync_on && !in_reset) ? H_SYNC_POL : !H_SYNC_POL;
    assign out_v_sync  = (v_sync_on && !in_reset) ? V_SYNC_POL : !V_SYNC_POL;

endmodule

// File: tb/tb_vga_sync_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_sync_timing_gen
//   Three instances share clock and reset: a small active-low raster, a
//   small active-high raster with zero vertical back porch, and the default
//   640x480 timing (only its first few lines fit in the run). The reference
//   derives position from the number of clocks since the last reset edge:
//   x = t mod H_TOTAL, y = (t div H_TOTAL) mod V_TOTAL, and evaluates the
//   blank/sync windows from the porch widths directly.
// ----------------------------------------------------------------------------
module tb_vga_sync_timing_gen;

    localparam int CYCLES = 4500;

    logic       clk;
    logic       rst;
    logic [9:0] ax, ay, bx, by, dx, dy;
    logic       ab, ahs, avs, bb, bhs, bvs, db, dhs, dvs;

    int n_chk = 0;
    int n_err = 0;

    vga_sync_timing_gen #(
        .H_ACTIVE(16), .H_FP(3), .H_SYNC(4), .H_BP(5),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)
    ) u_dut_a (
        .in_vga_clk(clk), .in_reset(rst),
        .out_pixel_x(ax), .out_pixel_y(ay), .out_blank_n(ab),
        .out_h_sync(ahs), .out_v_sync(avs)
    );

    vga_sync_timing_gen #(
        .H_ACTIVE(20), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(1), .V_BP(0),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
    ) u_dut_b (
        .in_vga_clk(clk), .in_reset(rst),
        .out_pixel_x(bx), .out_pixel_y(by), .out_blank_n(bb),
        .out_h_sync(bhs), .out_v_sync(bvs)
    );

    vga_sync_timing_gen u_dut_d (
        .in_vga_clk(clk), .in_reset(rst),
        .out_pixel_x(dx), .out_pixel_y(dy), .out_blank_n(db),
        .out_h_sync(dhs), .out_v_sync(dvs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference for one instance: t = clocks since the last reset edge.
    task automatic check_inst(
        input string nm, input int t,
        input int ha, input int hfp, input int hs, input int hbp,
        input int va, input int vfp, input int vs, input int vbp,
        input bit hp, input bit vp, input bit r,
        input logic [9:0] gx, input logic [9:0] gy,
        input logic gb, input logic ghs, input logic gvs);
        int  ht, vt, x, y;
        bit  eb, ehs, evs;
        ht  = ha + hfp + hs + hbp;
        vt  = va + vfp + vs + vbp;
        x   = t % ht;
        y   = (t / ht) % vt;
        eb  = !r && (x < ha) && (y < va);
        ehs = (!r && x >= ha + hfp && x < ha + hfp + hs) ? hp : !hp;
        evs = (!r && y >= va + vfp && y < va + vfp + vs) ? vp : !vp;
        chk({nm, "_x"},     32'(gx),  32'(x));
        chk({nm, "_y"},     32'(gy),  32'(y));
        chk({nm, "_blank"}, 32'(gb),  32'(eb));
        chk({nm, "_hsync"}, 32'(ghs), 32'(ehs));
        chk({nm, "_vsync"}, 32'(gvs), 32'(evs));
    endtask

    initial begin
        int  ta, tb, td;
        bit  mid_done;
        int  n_rst_seen;
        ta = 0; tb = 0; td = 0;
        mid_done   = 1'b0;
        n_rst_seen = 0;
        rst = 1'b1;
        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(posedge clk);
            if (rst) begin
                ta = 0; tb = 0; td = 0;
                n_rst_seen++;
            end else begin
                ta++; tb++; td++;
            end
            @(negedge clk);
            check_inst("a", ta, 16, 3, 4, 5, 10, 2, 2, 3, 1'b0, 1'b0, rst,
                       ax, ay, ab, ahs, avs);
            check_inst("b", tb, 20, 1, 2, 1, 6, 1, 1, 0, 1'b1, 1'b1, rst,
                       bx, by, bb, bhs, bvs);
            check_inst("d", td, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, rst,
                       dx, dy, db, dhs, dvs);

            // Next edge: 3-clock power-on reset, one mid-frame reset on the
            // small raster at (7,5), then sparse random resets.
            if (cyc < 2)
                rst = 1'b1;
            else if (!mid_done && cyc > 1200 && (ta % 28) == 7 && ((ta / 28) % 17) == 5) begin
                rst = 1'b1;
                mid_done = 1'b1;
            end else if (cyc > 2400 && $urandom_range(0, 399) == 0)
                rst = 1'b1;
            else
                rst = 1'b0;
        end
        chk("mid_reset_hit", 32'(mid_done), 32'd1);
        chk("reset_edges_min", 32'(n_rst_seen >= 4), 32'd1);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/vga_sync_timing_gen.md
Name: vga_sync_timing_gen

Overview:
Free-running VGA raster timing generator clocked by the pixel clock. It keeps horizontal and vertical position counters and produces pixel coordinates, an active-video (blank_n) flag, and horizontal/vertical sync pulses. It sits at the front of the VGA controller and drives the text-VRAM address generation, the font ROM lookup and the output sync/blank registers. Defaults give 640x480 @ 60 Hz (25.175 MHz pixel clock).

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_SYNC_POL, 0, level of out_h_sync while the pulse is asserted (0 = active-low)
V_SYNC_POL, 0, level of out_v_sync while the pulse is asserted (0 = active-low)

Constraints:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP must be ≤ 1024.
- V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP must be ≤ 1024.

Ports:
in_vga_clk  input  1  pixel clock; all state changes on the rising edge
in_reset  input  1  synchronous, active-high reset
out_pixel_x  output  10  current horizontal counter value h_cnt
out_pixel_y  output  10  current vertical counter value v_cnt
out_blank_n  output  1  1 = active video region, 0 = blanking
out_h_sync  output  1  horizontal sync, polarity per H_SYNC_POL
out_v_sync  output  1  vertical sync, polarity per V_SYNC_POL

Behaviour:
- Interface: one clock, in_vga_clk. in_reset is synchronous and active-high. No asynchronous reset path.
- State: the only state is two registered counters, h_cnt and v_cnt, each 10 bits.
- Reset: a rising edge with in_reset=1 sets h_cnt=0 and v_cnt=0.
- Outputs while in_reset=1:
  - out_blank_n = 0.
  - out_h_sync = !H_SYNC_POL and out_v_sync = !V_SYNC_POL (both deasserted).
  - out_pixel_x = 0 and out_pixel_y = 0 once the reset edge has occurred.
- Horizontal count: each clock, h_cnt increments. When h_cnt = H_TOTAL-1 it wraps to 0.
- Vertical count: v_cnt increments only on the clock where h_cnt wraps. When v_cnt = V_TOTAL-1 at that same edge, it wraps to 0, which starts a new frame.
- Line layout: active-video first, i.e. active, then front porch, sync, back porch.
- Output timing: all outputs are combinational decodes of the registered counters (plus in_reset), so they are mutually aligned in the same cycle with zero latency relative to the counters. The downstream controller adds its own one-cycle output register.
- Coordinates: out_pixel_x = h_cnt and out_pixel_y = v_cnt at all times, including blanking. During blanking the values exceed the active range (x up to 799, y up to 524 at defaults); consumers gate with blank_n.
- out_blank_n = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- h_sync is asserted when H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC. Asserted level = H_SYNC_POL; otherwise the inverse.
- v_sync is asserted when V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC, for whole lines. Its edges coincide with the h_cnt wrap to 0. Polarity per V_SYNC_POL.
- Mid-frame reset: reset asserted at any point restarts the frame at (0,0) on the next edge. There is no partial-line carry.
- No back-pressure and no enable: the generator is always running.
- Frame period = H_TOTAL*V_TOTAL clocks (420000 at defaults).

Test Plan:
1. Reset: hold in_reset=1 for 3 clocks → pixel_x=0, pixel_y=0, blank_n=0, h_sync=1, v_sync=1. On the first cycle after release → x=0, y=0, blank_n=1.
2. Line timing: from release, count clocks →
   - blank_n falls at x=640.
   - h_sync is low for x=656..751 (exactly 96 clocks) and high at x=752.
   - x wraps 799→0 while y goes 0→1.
3. Vertical timing:
   - blank_n stays 0 for the whole of lines 480..524.
   - v_sync is low from (x=0,y=490) through (x=799,y=491) (1600 clocks) and high at (0,492).
4. Frame wrap: after 420000 clocks (x=799,y=524) → next clock x=0, y=0, blank_n=1. The sync pattern repeats identically in the second frame.
5. Mid-frame reset: assert in_reset one clock at x=300, y=200 → next cycle x=0, y=0. Timing resumes exactly as in scenario 2.
6. Parameter override: H_SYNC_POL=1, V_SYNC_POL=1 → both syncs high only in their pulse windows, otherwise low. Counter and blank timing are unchanged.
